bc_io_intr: RTL and testbench

BC_IO_INTR -- requirements
Module: bc_io_intr

---
 rtl/bc_io_pkg.sv | 20 ++
 rtl/bc_io_chan.sv | 56 +++++
 rtl/bc_io_intr.sv | 139 +++++++++++++
 tb/tb_bc_io_intr.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bc_io_pkg.sv
// Shared definitions for the basic-computer I/O interrupt block:
// FSM state encoding, RT one-hot encodings and the default vector base.
package bc_io_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEND,
        ST_RT0,
        ST_RT1,
        ST_RT2
    } state_t;

    localparam logic [2:0] RT_NONE = 3'b000;
    localparam logic [2:0] RT0_OH  = 3'b001;
    localparam logic [2:0] RT1_OH  = 3'b010;
    localparam logic [2:0] RT2_OH  = 3'b100;

    localparam logic [11:0] VEC_BASE_DEFAULT = 12'h010;

endpackage

// File: rtl/bc_io_chan.sv
// One I/O channel: INPR/FGI/OVR on the input side, OUTR/FGO on the output side.
module bc_io_chan #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_strobe,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ack,
    input  logic              cpu_inp,
    input  logic              cpu_out,
    input  logic [DATA_W-1:0] ac_in,
    output logic [DATA_W-1:0] inpr,
    output logic [DATA_W-1:0] outr,
    output logic              fgi,
    output logic              fgo,
    output logic              ovr
);

    // A strobe on a full INPR is accepted only when the CPU drains it the same cycle.
    logic inpr_load;
    assign inpr_load = in_strobe && (!fgi || cpu_inp);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    // NOTE: INPR/OUTR are reset too, so a read after reset never returns stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inpr <= '0;
            outr <= '0;
            fgi  <= 1'b0;
            fgo  <= 1'b1;
            ovr  <= 1'b0;
        end else begin
            if (inpr_load)
                inpr <= in_data;

            if (in_strobe)
                fgi <= 1'b1;
            else if (cpu_inp)
                fgi <= 1'b0;

            if (cpu_inp)
                ovr <= 1'b0;
            else if (in_strobe && fgi)
                ovr <= 1'b1;

            if (cpu_out) begin
                outr <= ac_in;
                fgo  <= 1'b0;
            end else if (out_ack) begin
                fgo  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bc_io_intr.sv
// Multi-channel I/O with priority interrupt FSM (IDLE/PEND/RT0..RT2).
// Define BC_IO_VECTOR_EN for per-channel vectors; otherwise a single shared vector 0.
module bc_io_intr
    import bc_io_pkg::*;
#(
    parameter int                NUM_CH   = 4,
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] VEC_BASE = ADDR_W'(VEC_BASE_DEFAULT),
    localparam int               SEL_W    = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_strobe,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        out_ack,
    output logic [NUM_CH-1:0]        out_valid,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    input  logic [SEL_W-1:0]         ch_sel,
    input  logic                     cpu_inp,
    input  logic                     cpu_out,
    input  logic                     cpu_ion,
    input  logic                     cpu_iof,
    input  logic                     msk_wr,
    input  logic [DATA_W-1:0]        ac_in,
    input  logic [NUM_CH-1:0]        msk_in,
    input  logic                     t012,
    input  logic                     fetch_start,
    output logic [DATA_W-1:0]        inpr_out,
    output logic [NUM_CH-1:0]        fgi_vec,
    output logic [NUM_CH-1:0]        fgo_vec,
    output logic [NUM_CH-1:0]        ovr_vec,
    output logic                     ien,
    output logic                     r_flag,
    output logic [2:0]               int_rt,
    output logic [ADDR_W-1:0]        int_vec,
    output logic [SEL_W-1:0]         int_ch
);

    logic [DATA_W-1:0] inpr_arr [NUM_CH];
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] pending;
    logic [SEL_W-1:0]  lowest_ch;
    state_t            state, next_state;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        logic sel;
        assign sel = (ch_sel == SEL_W'(i));

        bc_io_chan #(.DATA_W(DATA_W)) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_strobe (in_strobe[i]),
            .in_data   (in_data[i*DATA_W +: DATA_W]),
            .out_ack   (out_ack[i]),
            .cpu_inp   (cpu_inp && sel),
            .cpu_out   (cpu_out && sel),
            .ac_in     (ac_in),
            .inpr      (inpr_arr[i]),
            .outr      (out_data[i*DATA_W +: DATA_W]),
            .fgi       (fgi_vec[i]),
            .fgo       (fgo_vec[i]),
            .ovr       (ovr_vec[i])
        );
    end

    assign out_valid = ~fgo_vec;
    assign inpr_out  = inpr_arr[ch_sel];
    assign pending   = (fgi_vec | fgo_vec) & mask;

    // Lowest index wins: scan from the top so the last hit is the smallest.
    always_comb begin
        lowest_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (pending[i])
                lowest_ch = SEL_W'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            int_ch <= '0;
            ien    <= 1'b0;
            mask   <= '0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && next_state == ST_PEND)
                int_ch <= lowest_ch;
            // Leaving RT2 drops IEN; a cpu_ion landing there is discarded.
            if (state == ST_RT2)
                ien <= 1'b0;
            else if (cpu_iof)
                ien <= 1'b0;
            else if (cpu_ion)
                ien <= 1'b1;
            if (msk_wr)
                mask <= msk_in;
        end
    end

    // NOTE: defaults first so no path through this block infers a latch.
    always_comb begin
        next_state = state;
        int_rt     = RT_NONE;
        r_flag     = 1'b0;
        unique case (state)
            ST_IDLE: if (ien && |pending && !t012) next_state = ST_PEND;
            ST_PEND: begin
                r_flag = 1'b1;
                if (fetch_start) next_state = ST_RT0;
            end
            ST_RT0: begin
                r_flag     = 1'b1;
                int_rt     = RT0_OH;
                next_state = ST_RT1;
            end
            ST_RT1: begin
                r_flag     = 1'b1;
                int_rt     = RT1_OH;
                next_state = ST_RT2;
            end
            ST_RT2: begin
                r_flag     = 1'b1;
                int_rt     = RT2_OH;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

`ifdef BC_IO_VECTOR_EN
    assign int_vec = (int_rt != RT_NONE) ? VEC_BASE + (ADDR_W'(int_ch) << 1) : '0;
`else
    logic unused_vec_base;
    assign unused_vec_base = ^VEC_BASE;
    assign int_vec = '0;
`endif

endmodule

// File: tb/tb_bc_io_intr.sv
// Directed self-checking bench for bc_io_intr (default parameters).
module tb_bc_io_intr;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 12;

`ifdef BC_IO_VECTOR_EN
    localparam logic [ADDR_W-1:0] EXP_VEC = 12'h012;
`else
    localparam logic [ADDR_W-1:0] EXP_VEC = 12'h000;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_CH-1:0]        in_strobe;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        out_ack;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic [1:0]               ch_sel;
    logic                     cpu_inp, cpu_out, cpu_ion, cpu_iof, msk_wr;
    logic [DATA_W-1:0]        ac_in;
    logic [NUM_CH-1:0]        msk_in;
    logic                     t012, fetch_start;
    logic [DATA_W-1:0]        inpr_out;
    logic [NUM_CH-1:0]        fgi_vec, fgo_vec, ovr_vec;
    logic                     ien, r_flag;
    logic [2:0]               int_rt;
    logic [ADDR_W-1:0]        int_vec;
    logic [1:0]               int_ch;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bc_io_intr #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_strobe   (in_strobe),
        .in_data     (in_data),
        .out_ack     (out_ack),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .ch_sel      (ch_sel),
        .cpu_inp     (cpu_inp),
        .cpu_out     (cpu_out),
        .cpu_ion     (cpu_ion),
        .cpu_iof     (cpu_iof),
        .msk_wr      (msk_wr),
        .ac_in       (ac_in),
        .msk_in      (msk_in),
        .t012        (t012),
        .fetch_start (fetch_start),
        .inpr_out    (inpr_out),
        .fgi_vec     (fgi_vec),
        .fgo_vec     (fgo_vec),
        .ovr_vec     (ovr_vec),
        .ien         (ien),
        .r_flag      (r_flag),
        .int_rt      (int_rt),
        .int_vec     (int_vec),
        .int_ch      (int_ch)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cmds();
        in_strobe = '0; out_ack = '0; cpu_inp = 0; cpu_out = 0;
        cpu_ion = 0; cpu_iof = 0; msk_wr = 0; fetch_start = 0;
    endtask

    initial begin
        rst_n = 0; in_data = '0; ch_sel = '0; ac_in = '0; msk_in = '0; t012 = 0;
        clear_cmds();
        step(); step();
        check("rst_fgo", fgo_vec, 4'hF);
        check("rst_out_valid", out_valid, 4'h0);
        check("rst_fgi", fgi_vec, 4'h0);
        check("rst_ien", ien, 0);
        check("rst_r_flag", r_flag, 0);
        check("rst_int_rt", int_rt, 3'b000);
        check("rst_int_vec", int_vec, 12'h000);
        rst_n = 1;
        step();

        // Input path: load, read, clear.
        in_strobe = 4'b0100; in_data = 32'h00A5_0000;
        step(); clear_cmds();
        ch_sel = 2;
        check("fgi2_set", fgi_vec, 4'b0100);
        check("inpr2", inpr_out, 8'hA5);
        cpu_inp = 1;
        step(); clear_cmds();
        check("fgi2_clr", fgi_vec, 4'b0000);

        // Overrun: second strobe while full keeps the first value.
        in_strobe = 4'b0010; in_data = 32'h0000_7700;
        step();
        in_data = 32'h0000_3C00;
        step(); clear_cmds();
        ch_sel = 1;
        check("inpr1_kept", inpr_out, 8'h77);
        check("ovr1_set", ovr_vec, 4'b0010);
        step();
        check("ovr1_sticky", ovr_vec, 4'b0010);
        cpu_inp = 1;
        step(); clear_cmds();
        check("ovr1_clr", ovr_vec, 4'b0000);
        check("fgi1_clr", fgi_vec, 4'b0000);

        // Strobe coinciding with cpu_inp on a full channel reloads without overrun.
        in_strobe = 4'b0010; in_data = 32'h0000_1100;
        step();
        in_data = 32'h0000_2200; cpu_inp = 1;
        step(); clear_cmds();
        check("exc_inpr", inpr_out, 8'h22);
        check("exc_fgi", fgi_vec, 4'b0010);
        check("exc_ovr", ovr_vec, 4'b0000);
        cpu_inp = 1;
        step(); clear_cmds();
        check("exc_fgi_clr", fgi_vec, 4'b0000);

        // Output path.
        ch_sel = 0; ac_in = 8'h5A; cpu_out = 1;
        step(); clear_cmds();
        check("out_valid0", out_valid, 4'b0001);
        check("out_data0", out_data[7:0], 8'h5A);
        out_ack = 4'b0001;
        step(); clear_cmds();
        check("out_ack0", out_valid, 4'b0000);
        ac_in = 8'hC3; cpu_out = 1; out_ack = 4'b0001;
        step(); clear_cmds();
        check("out_win", out_valid, 4'b0001);
        check("out_data_win", out_data[7:0], 8'hC3);

        // IEN control.
        cpu_ion = 1;
        step(); clear_cmds();
        check("ion", ien, 1);
        cpu_ion = 1; cpu_iof = 1;
        step(); clear_cmds();
        check("ion_iof", ien, 0);
        cpu_ion = 1;
        step(); clear_cmds();

        // Interrupt cycle; FGO[0]=0 so channel 1 is the lowest pending.
        t012 = 1; msk_wr = 1; msk_in = 4'hF;
        step(); clear_cmds();
        in_strobe = 4'b1010; in_data = 32'h4400_5500;
        step(); clear_cmds();
        check("t012_block", r_flag, 0);
        t012 = 0;
        step();
        check("pend_r_flag", r_flag, 1);
        check("pend_int_ch", int_ch, 1);
        check("pend_int_rt", int_rt, 3'b000);
        check("pend_int_vec", int_vec, 12'h000);
        step();
        check("pend_hold", r_flag, 1);
        fetch_start = 1;
        step(); clear_cmds();
        check("rt0", int_rt, 3'b001);
        check("rt0_vec", int_vec, EXP_VEC);
        step();
        check("rt1", int_rt, 3'b010);
        check("rt1_vec", int_vec, EXP_VEC);
        step();
        check("rt2", int_rt, 3'b100);
        check("rt2_vec", int_vec, EXP_VEC);
        cpu_ion = 1;
        step(); clear_cmds();
        check("post_ien", ien, 0);
        check("post_r_flag", r_flag, 0);
        check("post_int_rt", int_rt, 3'b000);
        check("post_int_vec", int_vec, 12'h000);

        // Reset during RT1.
        cpu_ion = 1;
        step(); clear_cmds();
        step();
        check("re_pend", r_flag, 1);
        fetch_start = 1;
        step(); clear_cmds();
        step();
        check("re_rt1", int_rt, 3'b010);
        #2 rst_n = 0;
        #1;
        check("mid_rst_int_rt", int_rt, 3'b000);
        check("mid_rst_r_flag", r_flag, 0);
        check("mid_rst_ien", ien, 0);
        check("mid_rst_fgo", fgo_vec, 4'hF);
        check("mid_rst_fgi", fgi_vec, 4'h0);
        step();
        rst_n = 1;
        step();
        check("idle_after_rst", r_flag, 0);
        check("idle_after_rst_rt", int_rt, 3'b000);
        cpu_ion = 1;
        step(); clear_cmds();
        step();
        check("mask_cleared", r_flag, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
